// File: rtl/mips_pkg.sv
// Shared MIPS constants: immediate-type opcodes, extender modes, and the packer's
// state and constant-class encodings.
package mips_pkg;

  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] EOP_SIGN  = 2'b00;
  localparam logic [1:0] EOP_ZERO  = 2'b01;
  localparam logic [1:0] EOP_UPPER = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_SINGLE = 2'd1,
    ST_FIRST  = 2'd2
  } pack_state_e;

  typedef enum logic [1:0] {
    CLS_SIGN  = 2'd0,
    CLS_ZERO  = 2'd1,
    CLS_UPPER = 2'd2,
    CLS_PAIR  = 2'd3
  } imm_cls_e;

endpackage

// File: rtl/imm_classify.sv
// Picks the shortest materialisation class for a 32-bit constant; the first
// matching class wins, so zero lands in the sign-extended addiu class.
module imm_classify
  import mips_pkg::*;
(
  input  logic [31:0] value,
  output imm_cls_e    cls
);

  logic sign_fit;

  assign sign_fit = (&value[31:15]) || ~(|value[31:15]);

  always_comb begin
    cls = CLS_PAIR;
    if (sign_fit)
      cls = CLS_SIGN;
    else if (value[31:16] == 16'h0000)
      cls = CLS_ZERO;
    else if (value[15:0] == 16'h0000)
      cls = CLS_UPPER;
  end

endmodule

// File: rtl/imm_packer.sv
// One-entry registered stage turning a constant plus destination register into
// one or two MIPS instructions (addiu/ori/lui, or lui+ori), each tagged with its EOp.
module imm_packer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [4:0]  in_rt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [1:0]  out_eop,
  output logic        out_last
);

  pack_state_e state_p0;
  logic [15:0] lo_p0;
  logic [4:0]  rt_p0;

  imm_cls_e    cls;
  logic        accept;
  logic [31:0] nxt_instr;
  logic [1:0]  nxt_eop;
  logic        nxt_last;
  pack_state_e nxt_state;

  imm_classify u_classify (
    .value (in_value),
    .cls   (cls)
  );

  assign in_ready = (state_p0 == ST_EMPTY) || ((state_p0 == ST_SINGLE) && out_ready);
  assign accept   = in_valid && in_ready;

  // First beat for the constant currently offered on the input side.
  always_comb begin
    nxt_instr = {OP_ADDIU, 5'd0, in_rt, in_value[15:0]};
    nxt_eop   = EOP_SIGN;
    nxt_last  = 1'b1;
    nxt_state = ST_SINGLE;
    case (cls)
      CLS_SIGN: begin
        nxt_instr = {OP_ADDIU, 5'd0, in_rt, in_value[15:0]};
        nxt_eop   = EOP_SIGN;
      end
      CLS_ZERO: begin
        nxt_instr = {OP_ORI, 5'd0, in_rt, in_value[15:0]};
        nxt_eop   = EOP_ZERO;
      end
      CLS_UPPER: begin
        nxt_instr = {OP_LUI, 5'd0, in_rt, in_value[31:16]};
        nxt_eop   = EOP_UPPER;
      end
      default: begin
        nxt_instr = {OP_LUI, 5'd0, in_rt, in_value[31:16]};
        nxt_eop   = EOP_UPPER;
        nxt_last  = 1'b0;
        nxt_state = ST_FIRST;
      end
    endcase
  end

  // Output register stage; reset drops both a held beat and any pending ori half.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0  <= ST_EMPTY;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_eop   <= EOP_SIGN;
      out_last  <= 1'b0;
    end else begin
      case (state_p0)
        ST_FIRST: begin
          if (out_ready) begin
            out_instr <= {OP_ORI, rt_p0, rt_p0, lo_p0};
            out_eop   <= EOP_ZERO;
            out_last  <= 1'b1;
            state_p0  <= ST_SINGLE;
          end
        end
        default: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_instr <= nxt_instr;
            out_eop   <= nxt_eop;
            out_last  <= nxt_last;
            state_p0  <= nxt_state;
            lo_p0     <= in_value[15:0];
            rt_p0     <= in_rt;
          end else if ((state_p0 == ST_SINGLE) && out_ready) begin
            out_valid <= 1'b0;
            state_p0  <= ST_EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_packer.sv
// Directed bench for imm_packer: single-beat classes, a stalled pair, a
// back-to-back stream and reset while the pair's lui is held.
module tb_imm_packer;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [4:0]  in_rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_eop;
  logic        out_last;

  logic [31:0] cls_value;
  imm_cls_e    cls_obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_packer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_rt     (in_rt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_eop   (out_eop),
    .out_last  (out_last)
  );

  imm_classify u_cls_chk (
    .value (cls_value),
    .cls   (cls_obs)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single_beat(input string tag, input logic [31:0] value, input logic [4:0] rt,
                             input logic [31:0] exp_instr, input logic [1:0] exp_eop);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_value  = value;
    in_rt     = rt;
    #1;
    check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check_eq({tag, " valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, " instr"}, out_instr, exp_instr);
    check_eq({tag, " eop"}, 32'(out_eop), 32'(exp_eop));
    check_eq({tag, " last"}, 32'(out_last), 32'd1);
    tick();
    check_eq({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [31:0] s_vals [4];
  logic [4:0]  s_rts  [4];
  logic [31:0] e_instr [5];
  logic        e_last  [5];
  logic [31:0] g_instr [8];
  logic        g_last  [8];
  int          g_cyc   [8];

  initial begin
    int idx, nb, stalls, seen;
    logic acc;

    reset = 1'b1; in_valid = 1'b0; in_value = '0; in_rt = '0; out_ready = 1'b0;
    cls_value = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst out_instr", out_instr, 32'd0);
    check_eq("rst out_eop", 32'(out_eop), 32'd0);
    check_eq("rst out_last", 32'(out_last), 32'd0);
    check_eq("rst in_ready", 32'(in_ready), 32'd1);

    cls_value = 32'h12345678; #1;
    check_eq("cls pair", 32'(cls_obs), 32'(CLS_PAIR));
    cls_value = 32'h00000000; #1;
    check_eq("cls zero value", 32'(cls_obs), 32'(CLS_SIGN));

    single_beat("addiu5",   32'h00000005, 5'd8,  32'h24080005, 2'b00);
    single_beat("addiuneg", 32'hFFFF8000, 5'd9,  32'h24098000, 2'b00);
    single_beat("ori8000",  32'h00008000, 5'd10, 32'h340A8000, 2'b01);
    single_beat("lui",      32'h12340000, 5'd11, 32'h3C0B1234, 2'b10);

    // Pair with three stall cycles on each beat
    out_ready = 1'b0;
    in_valid = 1'b1; in_value = 32'h12345678; in_rt = 5'd12;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("pair lui instr", out_instr, 32'h3C0C1234);
      check_eq("pair lui eop", 32'(out_eop), 32'd2);
      check_eq("pair lui last", 32'(out_last), 32'd0);
      check_eq("pair lui valid", 32'(out_valid), 32'd1);
      check_eq("pair lui in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1; #1;
    check_eq("pair first in_ready", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("pair ori instr", out_instr, 32'h358C5678);
      check_eq("pair ori eop", 32'(out_eop), 32'd1);
      check_eq("pair ori last", 32'(out_last), 32'd1);
      check_eq("pair ori in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1; #1;
    check_eq("pair ori consume in_ready", 32'(in_ready), 32'd1);
    tick();
    check_eq("pair drained", 32'(out_valid), 32'd0);

    // Back-to-back stream with out_ready held high
    s_vals[0] = 32'h00000005; s_rts[0] = 5'd8;
    s_vals[1] = 32'h0000ABCD; s_rts[1] = 5'd10;
    s_vals[2] = 32'h12345678; s_rts[2] = 5'd12;
    s_vals[3] = 32'h00000000; s_rts[3] = 5'd13;
    e_instr[0] = 32'h24080005; e_last[0] = 1'b1;
    e_instr[1] = 32'h340AABCD; e_last[1] = 1'b1;
    e_instr[2] = 32'h3C0C1234; e_last[2] = 1'b0;
    e_instr[3] = 32'h358C5678; e_last[3] = 1'b1;
    e_instr[4] = 32'h240D0000; e_last[4] = 1'b1;
    idx = 0; nb = 0; stalls = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (idx < 4) begin
        in_valid = 1'b1; in_value = s_vals[idx]; in_rt = s_rts[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) stalls++;
      tick();
      if (acc) idx++;
      if (out_valid && nb < 8) begin
        g_instr[nb] = out_instr; g_last[nb] = out_last; g_cyc[nb] = cyc; nb++;
      end
    end
    in_valid = 1'b0;
    check_eq("stream beats", 32'(nb), 32'd5);
    check_eq("stream stalls", 32'(stalls), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < nb) begin
        check_eq($sformatf("stream instr%0d", i), g_instr[i], e_instr[i]);
        check_eq($sformatf("stream last%0d", i), 32'(g_last[i]), 32'(e_last[i]));
        check_eq($sformatf("stream cycle%0d", i), 32'(g_cyc[i]), 32'(g_cyc[0] + i));
      end
    end

    // Reset while the lui of a pair is held; a constant offered during reset is dropped
    out_ready = 1'b0;
    in_valid = 1'b1; in_value = 32'hDEADBEEF; in_rt = 5'd14;
    tick();
    check_eq("rstpair lui", out_instr, 32'h3C0EDEAD);
    check_eq("rstpair lui last", 32'(out_last), 32'd0);
    reset = 1'b1; in_value = 32'h00000005; in_rt = 5'd1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("rstpair out_valid", 32'(out_valid), 32'd0);
    check_eq("rstpair in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check_eq("rstpair no beats", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_packer.md
# imm_packer

Inverse of the immediate extender: accepts a 32-bit constant plus destination register and emits the shortest MIPS instruction sequence that materialises it, each beat tagged with the extender mode (EOp) the datapath will apply. Sits upstream of instruction memory load / test-program generation in the single-cycle CPU. It is a one-entry registered stage with valid/ready on both sides, and it produces one or two output beats per accepted constant.

## Interface
- No parameters; all widths fixed by the MIPS ISA.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  constant offered.
- in_ready  out  1  constant accepted when in_valid && in_ready at a rising edge.
- in_value  in  32  constant to materialise.
- in_rt  in  5  destination register number.
- out_valid  out  1  out_instr valid.
- out_ready  in  1  consumer accepts the beat.
- out_instr  out  32  encoded instruction.
- out_eop  out  2  extender mode for this beat: 00 sign, 01 zero, 10 upper (lui).
- out_last  out  1  final beat of the current constant.

## Operation
- Classification of in_value, first match wins:
  - value[31:15] all equal -> addiu rt,$0,value[15:0]; {6'b001001,5'd0,rt,imm}; eop 00; one beat.
  - value[31:16]==0 -> ori rt,$0,value[15:0]; {6'b001101,5'd0,rt,imm}; eop 01; one beat.
  - value[15:0]==0 -> lui rt,value[31:16]; {6'b001111,5'd0,rt,imm}; eop 10; one beat.
  - otherwise -> lui rt,value[31:16] (eop 10, out_last 0), then ori rt,rt,value[15:0] ({6'b001101,rt,rt,lo}, eop 01, out_last 1).
- Value 0 takes the addiu path.
- rt==0 is not special-cased; the instructions are emitted normally.
- States:
  - EMPTY: no beat held.
  - SINGLE: holding a final beat.
  - FIRST: holding the lui of a pair; lo half and rt are stored internally.
- Transitions:
  - EMPTY + accept -> SINGLE (one-beat class) or FIRST (pair).
  - FIRST + out_ready -> SINGLE, loaded with the ori beat.
  - SINGLE + out_ready with no accept -> EMPTY.
  - SINGLE + out_ready with accept -> SINGLE or FIRST, per the new constant.
- in_ready = (state==EMPTY) || (state==SINGLE && out_ready). It is combinational from out_ready; no other input-to-output combinational path.
- While out_valid && !out_ready, out_instr, out_eop and out_last hold stable.

## Timing
- Reset values: state EMPTY, out_valid 0, out_instr 0, out_eop 00, out_last 0, in_ready 1 in the cycle after reset deasserts.
- Latency: constant accepted at edge N -> first beat has out_valid=1 after edge N.
- Throughput:
  - One-beat constants: one per cycle with out_ready held high.
  - Pairs: two cycles each.
- in_ready is low while in FIRST.
- Simultaneous final-beat consume and new accept: the new beat replaces the old one at the same edge, with no bubble.
- Reset mid-pair, including while in FIRST with out_ready low: the pending ori beat is discarded and the state returns to EMPTY. The consumer sees an orphan lui with out_last=0 followed by no further beats.
- A constant accepted in the same cycle reset is high is dropped.

## Structure
- Shared package (mips_pkg) holds:
  - Opcode constants OP_ADDIU 6'b001001, OP_ORI 6'b001101, OP_LUI 6'b001111.
  - EOp constants EOP_SIGN 2'b00, EOP_ZERO 2'b01, EOP_UPPER 2'b10.
  - State encoding.
- One combinational sub-module, imm_classify: in_value -> class (sign/zero/upper/pair). It is reused by the assembler checker in the bench.
- The rest is a single FSM plus output registers, roughly 150 lines.

## Test plan
- 0x00000005, rt=8 -> one beat 0x24080005, eop 00, last 1.
- 0xFFFF8000, rt=9 -> 0x24098000, eop 00, last 1. Also 0x00008000, rt=10 -> ori 0x340A8000, eop 01.
- 0x12340000, rt=11 -> lui 0x3C0B1234, eop 10, last 1.
- 0x12345678, rt=12 with out_ready stalled 3 cycles on each beat:
  - Beats 0x3C0C1234 (eop 10, last 0) then 0x358C5678 (eop 01, last 1), both held stable while stalled.
  - in_ready stays low until the ori beat is consumed.
- Back-to-back stream 5, 0x0000ABCD, 0x12345678, 0, with out_ready=1 throughout:
  - Beats in consecutive cycles: 0x24080005, 0x340AABCD, lui, ori, 0x24..0000.
  - Exactly one stall cycle on in_ready, during the pair.
- Reset asserted while in FIRST -> next cycle out_valid 0, in_ready 1; no ori beat ever appears.
